// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared types and widths for the memory bus arbiter and its watchdog.
//   state_e : arbiter sequencing states (IDLE -> BUS -> RESP -> IDLE)
//   owner_e : which port owns the transaction currently on the bus
//   XLEN    : address/data width
//   STRB_W  : byte-enable width
//   WDOG_W  : width of the bus timeout counter
// -----------------------------------------------------------------------------
package mem_bus_pkg;

   localparam int XLEN   = 32;
   localparam int STRB_W = 4;
   localparam int WDOG_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_e;

   typedef enum logic {
      OWN_FETCH,
      OWN_DATA
   } owner_e;

endpackage

// File: rtl/bus_watchdog.sv
// -----------------------------------------------------------------------------
// bus_watchdog
// Counts bus cycles spent waiting for an acknowledge and flags expiry so the
// arbiter can abort a transaction whose slave never answers.
// Ports:
//   clk_i       : clock
//   reset_i     : synchronous active-high reset
//   clear_i     : a new transaction is entering the bus; restart the count
//   active_i    : arbiter is in its bus phase this cycle
//   bus_ready_i : slave acknowledge
//   expired_o   : this is the last tolerated wait cycle and no acknowledge came
// -----------------------------------------------------------------------------
module bus_watchdog
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic active_i,
   input  logic bus_ready_i,
   output logic expired_o
);

   localparam logic [WDOG_W-1:0] LastCount = WDOG_W'(TIMEOUT_CYCLES - 1);

   logic [WDOG_W-1:0] count_q;
   logic [WDOG_W-1:0] count_d;

   // The count starts at zero on the first bus cycle, so comparing against
   // TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES bus cycles before abort.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (active_i && !bus_ready_i) begin
         count_d = count_q + WDOG_W'(1);
      end
   end

   // Plain register for the wait counter.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // An acknowledge in the final cycle still wins over the abort.
   assign expired_o = active_i && !bus_ready_i && (count_q == LastCount);

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one memory bus between the instruction fetch port and the memory
// stage data port. Each access is one bus transaction: grant, wait for the
// slave acknowledge, then a single-cycle response pulse back to the owner.
// Data always wins over fetch; a flush from the hazard unit discards any
// in-flight fetch response without abandoning the bus transaction itself.
//
// Optional feature: define BUS_TIMEOUT_EN to abort a bus transaction after
// TIMEOUT_CYCLES unacknowledged cycles, reporting it through *_error.
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   fetch_req/fetch_addr          : fetch request and word address
//   fetch_data/ready/error        : fetch response (data/error valid with ready)
//   flush                         : invalidate the pending fetch response
//   data_req/we/addr/wdata/strb   : load/store request
//   data_rdata/ready/error        : data response (rdata/error valid with ready)
//   bus_valid/addr/we/wdata/strb  : bus request side, stable for a transaction
//   bus_ready/bus_rdata           : slave acknowledge and read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [XLEN-1:0]   fetch_addr,
   output logic [XLEN-1:0]   fetch_data,
   output logic              fetch_ready,
   output logic              fetch_error,
   input  logic              flush,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [XLEN-1:0]   data_addr,
   input  logic [XLEN-1:0]   data_wdata,
   input  logic [STRB_W-1:0] data_strb,
   output logic [XLEN-1:0]   data_rdata,
   output logic              data_ready,
   output logic              data_error,
   output logic              bus_valid,
   output logic [XLEN-1:0]   bus_addr,
   output logic              bus_we,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [STRB_W-1:0] bus_strb,
   input  logic              bus_ready,
   input  logic [XLEN-1:0]   bus_rdata
);

   state_e              state_q;
   owner_e              owner_q;
   logic                drop_q;
   logic                err_q;
   logic                bus_valid_q;
   logic [XLEN-1:0]     bus_addr_q;
   logic                bus_we_q;
   logic [XLEN-1:0]     bus_wdata_q;
   logic [STRB_W-1:0]   bus_strb_q;
   logic [XLEN-1:0]     fetch_data_q;
   logic [XLEN-1:0]     data_rdata_q;
   logic                timeout_hit;

`ifdef BUS_TIMEOUT_EN
   logic enter_bus;

   // A grant in IDLE is the only way into BUS, so it doubles as the
   // watchdog restart.
   assign enter_bus = (state_q == IDLE) && (data_req || (fetch_req && !flush));

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_bus_watchdog (
      .clk_i       (clk),
      .reset_i     (reset),
      .clear_i     (enter_bus),
      .active_i    (state_q == BUS),
      .bus_ready_i (bus_ready),
      .expired_o   (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Sequencer: grants in IDLE with data taking priority, holds the latched
   // bus fields through BUS, captures read data into the owner's response
   // register, and spends exactly one RESP cycle before returning to IDLE.
   // No grant is made in RESP, so a requester still holding its request on
   // its ready cycle is not served twice.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= OWN_FETCH;
         drop_q       <= 1'b0;
         err_q        <= 1'b0;
         bus_valid_q  <= 1'b0;
         bus_addr_q   <= '0;
         bus_we_q     <= 1'b0;
         bus_wdata_q  <= '0;
         bus_strb_q   <= '0;
         fetch_data_q <= '0;
         data_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               drop_q <= 1'b0;
               err_q  <= 1'b0;
               if (data_req) begin
                  owner_q     <= OWN_DATA;
                  bus_addr_q  <= data_addr;
                  bus_we_q    <= data_we;
                  bus_wdata_q <= data_wdata;
                  bus_strb_q  <= data_strb;
                  bus_valid_q <= 1'b1;
                  state_q     <= BUS;
               end else if (fetch_req && !flush) begin
                  owner_q     <= OWN_FETCH;
                  bus_addr_q  <= fetch_addr;
                  bus_we_q    <= 1'b0;
                  bus_wdata_q <= '0;
                  bus_strb_q  <= '1;
                  bus_valid_q <= 1'b1;
                  state_q     <= BUS;
               end
            end
            BUS: begin
               // The fetch transaction keeps running on the bus; only its
               // response is thrown away later.
               if ((owner_q == OWN_FETCH) && flush) begin
                  drop_q <= 1'b1;
               end
               if (bus_ready) begin
                  bus_valid_q <= 1'b0;
                  state_q     <= RESP;
                  if (owner_q == OWN_FETCH) begin
                     fetch_data_q <= bus_rdata;
                  end else begin
                     data_rdata_q <= bus_rdata;
                  end
               end else if (timeout_hit) begin
                  bus_valid_q <= 1'b0;
                  err_q       <= 1'b1;
                  state_q     <= RESP;
                  if (owner_q == OWN_FETCH) begin
                     fetch_data_q <= '0;
                  end else begin
                     data_rdata_q <= '0;
                  end
               end
            end
            RESP: begin
               drop_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               bus_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   // The fetch pulse is also gated by a flush arriving in the RESP cycle
   // itself, which the drop flag cannot have seen yet.
   assign fetch_ready = (state_q == RESP) && (owner_q == OWN_FETCH) && !drop_q && !flush;
   assign data_ready  = (state_q == RESP) && (owner_q == OWN_DATA);
   assign fetch_error = fetch_ready && err_q;
   assign data_error  = data_ready && err_q;

   assign fetch_data = fetch_data_q;
   assign data_rdata = data_rdata_q;
   assign bus_valid  = bus_valid_q;
   assign bus_addr   = bus_addr_q;
   assign bus_we     = bus_we_q;
   assign bus_wdata  = bus_wdata_q;
   assign bus_strb   = bus_strb_q;

endmodule
